// File: rtl/multiplexer_4to1_rr.sv
// Four-channel valid/ready stream merger with round-robin arbitration, packet lock
// on in_last and a single registered output stage carrying the source channel index.
module multiplexer_4to1_rr #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            in_valid,
    input  logic [4*DATA_W-1:0]   in_data,
    input  logic [3:0]            in_last,
    output logic [3:0]            in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_sel,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  o_dbg_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_ptr;
    logic [1:0]          r_lock_ch;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [1:0]          r_out_sel;
    logic                r_out_last;

    logic                w_load;
    logic                w_found;
    logic [1:0]          w_grant;
    logic [1:0]          w_src;
    logic [3:0]          w_ready;
    logic                w_xfer;
    logic                w_beat_last;
    logic [DATA_W-1:0]   w_beat_data;

    // Handshake: a beat moves on channel i when in_valid[i] && in_ready[i];
    // the output beat moves when out_valid && out_ready. The output slot can
    // take a new beat when it is empty or being drained in the same cycle.
    assign w_load = !r_out_valid || out_ready;

    // First valid channel scanning from r_ptr upward, wrapping mod 4.
    always_comb begin
        w_grant = r_ptr;
        w_found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[r_ptr + 2'(k)]) begin
                w_grant = r_ptr + 2'(k);
                w_found = 1'b1;
            end
        end
    end

    assign w_src       = (r_state == ST_LOCK) ? r_lock_ch : w_grant;
    assign w_xfer      = |(in_valid & w_ready);
    assign w_beat_last = in_last[w_src];
    assign w_beat_data = in_data[w_src*DATA_W +: DATA_W];

    // State register; pointer and lock channel follow the accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 2'd0;
            r_lock_ch <= 2'd0;
        end else begin
            r_state <= w_next_state;
            if (w_xfer) begin
                if (w_beat_last) begin
                    r_ptr <= w_src + 2'd1;
                end
                if (r_state == ST_IDLE && !w_beat_last) begin
                    r_lock_ch <= w_src;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_xfer && !w_beat_last) w_next_state = ST_LOCK;
            ST_LOCK: if (w_xfer && w_beat_last)  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // A locked channel is offered the slot whether or not it is currently valid.
    always_comb begin
        w_ready = 4'b0000;
        if (!rst && w_load) begin
            if (r_state == ST_LOCK) begin
                w_ready[r_lock_ch] = 1'b1;
            end else if (w_found) begin
                w_ready[w_grant] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= 2'd0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_beat_data;
                r_out_sel   <= w_src;
                r_out_last  <= w_beat_last;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready    = w_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_sel     = r_out_sel;
    assign out_last    = r_out_last;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multiplexer_4to1_rr.sv
// Directed bench for multiplexer_4to1_rr: a table of per-cycle vectors with
// hand-computed in_ready/out_* values, plus reset sequences written out by hand.
module tb_multiplexer_4to1_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  in_valid = 4'b0;
    logic [31:0] in_data = 32'h0;
    logic [3:0]  in_last = 4'b0;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        dbg_state;

    int n_chk  = 0;
    int n_fail = 0;

    multiplexer_4to1_rr #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
        .out_ready(out_ready), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  iv;
        logic [31:0] d;
        logic [3:0]  il;
        logic        ordy;
        logic [3:0]  er;
        logic        ev;
        logic [7:0]  ed;
        logic [1:0]  es;
        logic        el;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(logic [3:0] iv, logic [31:0] d, logic [3:0] il, logic ordy,
                                logic [3:0] er, logic ev, logic [7:0] ed, logic [1:0] es,
                                logic el);
        vec_t v;
        v.iv = iv; v.d = d; v.il = il; v.ordy = ordy;
        v.er = er; v.ev = ev; v.ed = ed; v.es = es; v.el = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1: drive, check in_ready before the edge, check outputs after it.
    task automatic step(input string tag, input vec_t v);
        in_valid  = v.iv;
        in_data   = v.d;
        in_last   = v.il;
        out_ready = v.ordy;
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(v.er));
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(v.ev));
        chk({tag, " out_data"},  32'(out_data),  32'(v.ed));
        chk({tag, " out_sel"},   32'(out_sel),   32'(v.es));
        chk({tag, " out_last"},  32'(out_last),  32'(v.el));
    endtask

    localparam logic [31:0] B = 32'hD3C2B1A0;

    initial begin
        // round robin over four single-beat channels
        vecs[0]  = mk(4'b1111, B, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1);
        vecs[1]  = mk(4'b1111, B, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1, 1'b1);
        vecs[2]  = mk(4'b1111, B, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2, 1'b1);
        vecs[3]  = mk(4'b1111, B, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3, 1'b1);
        vecs[4]  = mk(4'b1111, B, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1);
        // three-beat packet on ch2 while ch0/ch1 stay valid
        vecs[5]  = mk(4'b0010, B, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1, 1'b1);
        vecs[6]  = mk(4'b0111, 32'hD311B1A0, 4'b0011, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd2, 1'b0);
        vecs[7]  = mk(4'b0111, 32'hD322B1A0, 4'b0011, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2, 1'b0);
        vecs[8]  = mk(4'b0111, 32'hD333B1A0, 4'b0111, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2, 1'b1);
        vecs[9]  = mk(4'b1011, B, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3, 1'b1);
        vecs[10] = mk(4'b0011, B, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1);
        // 0x5A held under five cycles of backpressure
        vecs[11] = mk(4'b0010, 32'hD3C25AA0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h5A, 2'd1, 1'b1);
        for (int i = 12; i <= 16; i++)
            vecs[i] = mk(4'b0100, 32'hD377B1A0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h5A, 2'd1, 1'b1);
        vecs[17] = mk(4'b0100, 32'hD377B1A0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h77, 2'd2, 1'b1);
        vecs[18] = mk(4'b0000, B, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h77, 2'd2, 1'b1);
        vecs[19] = mk(4'b0000, B, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h77, 2'd2, 1'b1);
        // lock on ch1, ch1 idles three cycles while ch3 waits
        vecs[20] = mk(4'b0010, 32'hD3C241A0, 4'b1101, 1'b1, 4'b0010, 1'b1, 8'h41, 2'd1, 1'b0);
        for (int i = 21; i <= 23; i++)
            vecs[i] = mk(4'b1000, B, 4'b1111, 1'b1, 4'b0010, 1'b0, 8'h41, 2'd1, 1'b0);
        vecs[24] = mk(4'b1010, 32'hD3C242A0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h42, 2'd1, 1'b1);
        vecs[25] = mk(4'b1000, B, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3, 1'b1);

        // reset held with every channel valid
        in_valid = 4'b1111; in_data = B; in_last = 4'b1111; out_ready = 1'b1;
        #1 rst = 1'b1;
        #11;
        chk("rst in_ready",  32'(in_ready),  32'h0);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst out_sel",   32'(out_sel),   32'h0);
        chk("rst out_data",  32'(out_data),  32'h0);
        chk("rst state",     32'(dbg_state), 32'h0);
        in_valid = 4'b0000;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) step($sformatf("v%0d", i), vecs[i]);

        // reset in the middle of a ch2 packet with ptr parked at 2
        step("r0", mk(4'b0010, B, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1, 1'b1));
        step("r1", mk(4'b0100, 32'hD364B1A0, 4'b1011, 1'b1, 4'b0100, 1'b1, 8'h64, 2'd2, 1'b0));
        chk("r1 state lock", 32'(dbg_state), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async out_valid", 32'(out_valid), 32'h0);
        chk("async out_data",  32'(out_data),  32'h0);
        chk("async out_sel",   32'(out_sel),   32'h0);
        chk("async out_last",  32'(out_last),  32'h0);
        chk("async state",     32'(dbg_state), 32'h0);
        in_valid = 4'b0101; in_data = 32'hD363B162; in_last = 4'b1111; out_ready = 1'b1;
        #1;
        chk("rst hold in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("post rst in_ready", 32'(in_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("post rst out_valid", 32'(out_valid), 32'h1);
        chk("post rst out_data",  32'(out_data),  32'h62);
        chk("post rst out_sel",   32'(out_sel),   32'h0);
        chk("post rst out_last",  32'(out_last),  32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
